// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the LEGv8 fetch sequencer: fetch FSM states,
// instruction size and the default reset vector.
package pc_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned INSN_BYTES           = 4;
  localparam int unsigned DEFAULT_INSN_W       = 32;
  localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;

  // A resolved control-flow instruction only redirects when it is actually taken.
  function automatic logic branch_taken(
    input logic valid,
    input logic branch,
    input logic alu_zero,
    input logic uncond
  );
    return valid & (uncond | (branch & alu_zero));
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Bundle of the imem, decode and execute-redirect signals around the fetch sequencer.
// master = the sequencer itself, slave = the surrounding pipeline/memory.
interface pc_fetch_sequencer_if
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int INSN_W = DEFAULT_INSN_W
);

  logic              ImemReqValid;
  logic [63:0]       ImemReqAddr;
  logic              ImemReqReady;
  logic              ImemRspValid;
  logic [INSN_W-1:0] ImemRspData;

  logic              InsnValid;
  logic [INSN_W-1:0] Insn;
  logic [63:0]       InsnPC;
  logic              InsnReady;

  logic              BranchValid;
  logic [63:0]       BranchPC;
  logic [63:0]       SignExtImm64;
  logic              Branch;
  logic              ALUZero;
  logic              Uncondbranch;

  logic [63:0]       CurrentPC;

  modport master (
    output ImemReqValid, ImemReqAddr, InsnValid, Insn, InsnPC, CurrentPC,
    input  ImemReqReady, ImemRspValid, ImemRspData, InsnReady,
    input  BranchValid, BranchPC, SignExtImm64, Branch, ALUZero, Uncondbranch
  );

  modport slave (
    input  ImemReqValid, ImemReqAddr, InsnValid, Insn, InsnPC, CurrentPC,
    output ImemReqReady, ImemRspValid, ImemRspData, InsnReady,
    output BranchValid, BranchPC, SignExtImm64, Branch, ALUZero, Uncondbranch
  );

endinterface

// File: rtl/pc_fetch_sequencer_next_pc_logic.sv
// LEGv8 next-PC logic: branch target when a branch condition holds, else PC+4.
// The offset arrives already byte-scaled, so no shift is applied here.
module pc_fetch_sequencer_next_pc_logic
  import pc_fetch_sequencer_pkg::*;
(
  input  logic [63:0] current_pc,
  input  logic [63:0] sign_ext_imm64,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic        uncond_branch,
  output logic [63:0] next_pc
);

  always_comb begin
    if (uncond_branch | (branch & alu_zero)) begin
      next_pc = current_pc + sign_ext_imm64;
    end else begin
      next_pc = current_pc + 64'(INSN_BYTES);
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Architectural PC owner and single-outstanding instruction fetch sequencer
// between imem and decode, with execute-stage redirect and in-flight squash.
//
// state | meaning
// REQ   | request for CurrentPC presented to imem until accepted
// WAIT  | request accepted, waiting for the read-data pulse
// HOLD  | fetched word held toward decode until taken
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          INSN_W       = DEFAULT_INSN_W
) (
  input logic                  CLK,
  input logic                  Reset,
  pc_fetch_sequencer_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [63:0]       current_pc_q, current_pc_d;
  logic [63:0]       insn_pc_q, insn_pc_d;
  logic [INSN_W-1:0] insn_q, insn_d;
  logic              squash_q, squash_d;
  logic              req_valid_q, req_valid_d;
  logic              insn_valid_q, insn_valid_d;

  logic              taken;
  logic              req_fire;
  logic              insn_fire;
  logic [63:0]       target;
  logic [63:0]       pc_plus4;

  pc_fetch_sequencer_next_pc_logic u_next_pc_logic (
    .current_pc     (bus.BranchPC),
    .sign_ext_imm64 (bus.SignExtImm64),
    .branch         (bus.Branch),
    .alu_zero       (bus.ALUZero),
    .uncond_branch  (bus.Uncondbranch),
    .next_pc        (target)
  );

  assign taken     = branch_taken(bus.BranchValid, bus.Branch, bus.ALUZero, bus.Uncondbranch);
  assign req_fire  = req_valid_q & bus.ImemReqReady;
  assign insn_fire = insn_valid_q & bus.InsnReady;
  assign pc_plus4  = current_pc_q + 64'(INSN_BYTES);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_REQ;
      current_pc_q <= RESET_VECTOR;
      insn_pc_q    <= '0;
      insn_q       <= '0;
      squash_q     <= 1'b0;
      req_valid_q  <= 1'b0;
      insn_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      current_pc_q <= current_pc_d;
      insn_pc_q    <= insn_pc_d;
      insn_q       <= insn_d;
      squash_q     <= squash_d;
      req_valid_q  <= req_valid_d;
      insn_valid_q <= insn_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    current_pc_d = current_pc_q;
    insn_pc_d    = insn_pc_q;
    insn_d       = insn_q;
    squash_d     = squash_q;
    insn_valid_d = insn_valid_q;

    case (state_q)
      ST_REQ: begin
        if (req_fire) begin
          state_d = ST_WAIT;
          // The request just issued is for the old path; drop its data on return.
          if (taken) begin
            squash_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (bus.ImemRspValid) begin
          if (taken || squash_q) begin
            squash_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            insn_d       = bus.ImemRspData;
            insn_pc_d    = current_pc_q;
            current_pc_d = pc_plus4;
            insn_valid_d = 1'b1;
            state_d      = ST_HOLD;
          end
        end else if (taken) begin
          squash_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (taken || insn_fire) begin
          insn_valid_d = 1'b0;
          state_d      = ST_REQ;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase

    // Redirect outranks every state transition above.
    if (taken) begin
      current_pc_d = target;
    end

    req_valid_d = (state_d == ST_REQ);
  end

  always_comb begin
    bus.ImemReqValid = req_valid_q;
    bus.ImemReqAddr  = current_pc_q;
    bus.InsnValid    = insn_valid_q;
    bus.Insn         = insn_q;
    bus.InsnPC       = insn_pc_q;
    bus.CurrentPC    = current_pc_q;
  end

  a_hold_matches_valid : assert property (
    @(posedge CLK) disable iff (Reset) insn_valid_q == (state_q == ST_HOLD)
  );

  a_req_addr_stable : assert property (
    @(posedge CLK) disable iff (Reset)
      (req_valid_q && !bus.ImemReqReady && !taken) |=> (req_valid_q && $stable(current_pc_q))
  );

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: table of plain fetches feeding a
// scoreboard of expected {InsnPC, Insn}, then hand-written redirect/wrap/reset sequences.
module tb_pc_fetch_sequencer;

  localparam int INSN_W = 32;

  logic CLK = 1'b0;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  pc_fetch_sequencer_if #(.INSN_W(INSN_W)) bus ();

  pc_fetch_sequencer #(
    .RESET_VECTOR (64'h0),
    .INSN_W       (INSN_W)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] insn;
  } sb_entry_t;

  typedef struct {
    int          req_stall;
    int          rsp_delay;
    int          dec_stall;
    logic [31:0] data;
    logic [63:0] exp_addr;
  } fetch_vec_t;

  sb_entry_t  sb_q[$];
  fetch_vec_t vecs[6];

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Samples the decode handshake just before the edge, then advances one cycle.
  task automatic tick();
    sb_entry_t e;
    if (bus.InsnValid && bus.InsnReady) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: transfer pc=%h insn=%h, expected no transfer",
                 bus.InsnPC, bus.Insn);
      end else begin
        e = sb_q.pop_front();
        chk64("sb_pc", bus.InsnPC, e.pc);
        chk64("sb_insn", 64'(bus.Insn), 64'(e.insn));
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic clear_branch();
    bus.BranchValid  = 1'b0;
    bus.BranchPC     = 64'h0;
    bus.SignExtImm64 = 64'h0;
    bus.Branch       = 1'b0;
    bus.ALUZero      = 1'b0;
    bus.Uncondbranch = 1'b0;
  endtask

  task automatic uncond_redirect(input logic [63:0] bpc, input logic [63:0] imm);
    bus.BranchValid  = 1'b1;
    bus.Uncondbranch = 1'b1;
    bus.BranchPC     = bpc;
    bus.SignExtImm64 = imm;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!bus.ImemReqValid && n < 20) begin
      tick();
      n++;
    end
    chk1({name, "_req_valid"}, bus.ImemReqValid, 1'b1);
  endtask

  task automatic do_fetch(input string name, input int req_stall, input int rsp_delay,
                          input int dec_stall, input logic [31:0] data,
                          input logic [63:0] exp_addr, input bit stay_hold);
    bus.ImemReqReady = 1'b0;
    wait_req(name);
    for (int i = 0; i < req_stall; i++) begin
      tick();
      chk1({name, "_stall_valid"}, bus.ImemReqValid, 1'b1);
      chk64({name, "_stall_addr"}, bus.ImemReqAddr, exp_addr);
    end
    chk64({name, "_addr"}, bus.ImemReqAddr, exp_addr);
    bus.ImemReqReady = 1'b1;
    tick();
    bus.ImemReqReady = 1'b0;
    chk1({name, "_no_dup"}, bus.ImemReqValid, 1'b0);
    for (int i = 1; i < rsp_delay; i++) begin
      tick();
      chk1({name, "_wait_req"}, bus.ImemReqValid, 1'b0);
      chk1({name, "_wait_insn"}, bus.InsnValid, 1'b0);
    end
    bus.ImemRspValid = 1'b1;
    bus.ImemRspData  = data;
    if (!stay_hold) sb_q.push_back('{exp_addr, data});
    tick();
    bus.ImemRspValid = 1'b0;
    bus.ImemRspData  = '0;
    chk1({name, "_latency"}, bus.InsnValid, 1'b1);
    chk64({name, "_next_pc"}, bus.CurrentPC, exp_addr + 64'd4);
    if (!stay_hold) begin
      for (int i = 0; i < dec_stall; i++) begin
        tick();
        chk1({name, "_hold"}, bus.InsnValid, 1'b1);
      end
      bus.InsnReady = 1'b1;
      tick();
      bus.InsnReady = 1'b0;
      chk1({name, "_release"}, bus.InsnValid, 1'b0);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk1({name, "_req_valid"}, bus.ImemReqValid, 1'b0);
    chk64({name, "_req_addr"}, bus.ImemReqAddr, 64'h0);
    chk64({name, "_cur_pc"}, bus.CurrentPC, 64'h0);
    chk1({name, "_insn_valid"}, bus.InsnValid, 1'b0);
    chk64({name, "_insn"}, 64'(bus.Insn), 64'h0);
    chk64({name, "_insn_pc"}, bus.InsnPC, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;

    Reset            = 1'b1;
    bus.ImemReqReady = 1'b0;
    bus.ImemRspValid = 1'b0;
    bus.ImemRspData  = '0;
    bus.InsnReady    = 1'b0;
    clear_branch();

    vecs[0] = '{0, 1, 0, 32'h8B02_0020, 64'h0};
    vecs[1] = '{0, 1, 0, 32'hCB03_0041, 64'h4};
    vecs[2] = '{0, 1, 0, 32'hF840_0062, 64'h8};
    vecs[3] = '{0, 3, 2, 32'hB400_0083, 64'hC};
    vecs[4] = '{5, 1, 0, 32'h1400_00A4, 64'h10};
    vecs[5] = '{1, 2, 1, 32'hD100_04C5, 64'h14};

    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outputs("rst");
    Reset = 1'b0;

    c0 = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) c0 = cyc;
      do_fetch($sformatf("vec%0d", i), vecs[i].req_stall, vecs[i].rsp_delay,
               vecs[i].dec_stall, vecs[i].data, vecs[i].exp_addr, 1'b0);
      if (i == 2) chk64("throughput", 64'(cyc - c0), 64'd6);
    end

    // Redirect while waiting: returning word dropped, refetch at 0x40+0x20.
    bus.ImemReqReady = 1'b0;
    wait_req("t3");
    chk64("t3_addr", bus.ImemReqAddr, 64'h18);
    bus.ImemReqReady = 1'b1;
    tick();
    bus.ImemReqReady = 1'b0;
    uncond_redirect(64'h40, 64'h20);
    tick();
    clear_branch();
    chk64("t3_cur_pc", bus.CurrentPC, 64'h60);
    chk1("t3_still_wait", bus.ImemReqValid, 1'b0);
    bus.ImemRspValid = 1'b1;
    bus.ImemRspData  = 32'hDEAD_BEEF;
    tick();
    bus.ImemRspValid = 1'b0;
    chk1("t3_drop", bus.InsnValid, 1'b0);
    chk1("t3_req_valid", bus.ImemReqValid, 1'b1);
    chk64("t3_req_addr", bus.ImemReqAddr, 64'h60);
    do_fetch("t3_resume", 0, 1, 0, 32'h9100_0421, 64'h60, 1'b0);

    // Conditional redirect in the same cycle as the response.
    wait_req("t3b");
    bus.ImemReqReady = 1'b1;
    tick();
    bus.ImemReqReady = 1'b0;
    bus.ImemRspValid = 1'b1;
    bus.ImemRspData  = 32'h1111_2222;
    bus.BranchValid  = 1'b1;
    bus.Branch       = 1'b1;
    bus.ALUZero      = 1'b1;
    bus.BranchPC     = 64'h100;
    bus.SignExtImm64 = 64'h8;
    tick();
    bus.ImemRspValid = 1'b0;
    clear_branch();
    chk1("t3b_drop", bus.InsnValid, 1'b0);
    chk1("t3b_req_valid", bus.ImemReqValid, 1'b1);
    chk64("t3b_req_addr", bus.ImemReqAddr, 64'h108);

    // Redirect in the cycle the request is accepted: that request's data is squashed.
    bus.ImemReqReady = 1'b1;
    uncond_redirect(64'h200, 64'h40);
    tick();
    bus.ImemReqReady = 1'b0;
    clear_branch();
    chk1("t3c_wait", bus.ImemReqValid, 1'b0);
    chk64("t3c_cur_pc", bus.CurrentPC, 64'h240);
    bus.ImemRspValid = 1'b1;
    bus.ImemRspData  = 32'h3333_4444;
    tick();
    bus.ImemRspValid = 1'b0;
    chk1("t3c_drop", bus.InsnValid, 1'b0);
    chk64("t3c_req_addr", bus.ImemReqAddr, 64'h240);

    // Redirect while the request is not accepted: address changes next cycle.
    uncond_redirect(64'h300, 64'h10);
    tick();
    clear_branch();
    chk1("t3d_req_valid", bus.ImemReqValid, 1'b1);
    chk64("t3d_req_addr", bus.ImemReqAddr, 64'h310);
    do_fetch("t3d", 0, 1, 0, 32'h5555_6666, 64'h310, 1'b0);

    // Not-taken then taken conditional branch while holding.
    do_fetch("t4", 0, 1, 0, 32'h7777_8888, 64'h314, 1'b1);
    bus.BranchValid  = 1'b1;
    bus.Branch       = 1'b1;
    bus.ALUZero      = 1'b0;
    bus.BranchPC     = 64'h500;
    bus.SignExtImm64 = 64'h100;
    tick();
    chk1("t4_nt_valid", bus.InsnValid, 1'b1);
    chk64("t4_nt_pc", bus.CurrentPC, 64'h318);
    chk64("t4_nt_insn_pc", bus.InsnPC, 64'h314);
    chk64("t4_nt_insn", 64'(bus.Insn), 64'h7777_8888);
    bus.ALUZero = 1'b1;
    tick();
    clear_branch();
    chk1("t4_t_valid", bus.InsnValid, 1'b0);
    chk64("t4_t_pc", bus.CurrentPC, 64'h600);
    chk1("t4_t_req_valid", bus.ImemReqValid, 1'b1);
    chk64("t4_t_req_addr", bus.ImemReqAddr, 64'h600);

    // Taken in HOLD with InsnReady in the same cycle still transfers the word.
    do_fetch("t4b", 0, 1, 0, 32'h9999_AAAA, 64'h600, 1'b1);
    sb_q.push_back('{64'h600, 32'h9999_AAAA});
    bus.InsnReady = 1'b1;
    uncond_redirect(64'hFFFF_FFFF_FFFF_FF00, 64'hFC);
    tick();
    bus.InsnReady = 1'b0;
    clear_branch();
    chk1("t4b_valid", bus.InsnValid, 1'b0);
    chk64("t4b_req_addr", bus.ImemReqAddr, 64'hFFFF_FFFF_FFFF_FFFC);

    // PC+4 and target arithmetic wrap modulo 2^64; misaligned target is fetched as-is.
    do_fetch("t5_top", 0, 1, 0, 32'hABCD_0001, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    chk1("t5_wrap_valid", bus.ImemReqValid, 1'b1);
    chk64("t5_wrap_addr", bus.ImemReqAddr, 64'h0);
    uncond_redirect(64'h8, 64'hFFFF_FFFF_FFFF_FFF0);
    tick();
    clear_branch();
    chk64("t5_neg_addr", bus.ImemReqAddr, 64'hFFFF_FFFF_FFFF_FFF8);
    do_fetch("t5_neg", 0, 1, 0, 32'hABCD_0002, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    uncond_redirect(64'h1000, 64'h3);
    tick();
    clear_branch();
    chk64("t5_mis_addr", bus.ImemReqAddr, 64'h1003);
    do_fetch("t5_mis", 0, 1, 0, 32'hABCD_0003, 64'h1003, 1'b0);

    // Reset in WAIT; the late response must be ignored.
    wait_req("t6");
    bus.ImemReqReady = 1'b1;
    tick();
    bus.ImemReqReady = 1'b0;
    Reset = 1'b1;
    #1;
    chk_reset_outputs("t6_async");
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    bus.ImemRspValid = 1'b1;
    bus.ImemRspData  = 32'hBADB_AD00;
    tick();
    bus.ImemRspValid = 1'b0;
    bus.ImemRspData  = '0;
    chk1("t6_stale_valid", bus.InsnValid, 1'b0);
    chk64("t6_stale_insn", 64'(bus.Insn), 64'h0);
    chk64("t6_stale_pc", bus.CurrentPC, 64'h0);
    do_fetch("t6", 0, 1, 0, 32'h0123_4567, 64'h0, 1'b0);

    chk64("sb_empty", 64'(sb_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
